// File: rtl/carry_save_pkg.sv
// Shared constants for the three-operand carry-save adder.
package carry_save_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned RESULT_WIDTH  = DEFAULT_WIDTH + 2;

    // {Cout, S} for operands of width w: three operands add at most two bits of growth.
    function automatic int unsigned result_width(input int unsigned w);
        return w + 2;
    endfunction

endpackage

// File: rtl/carry_save_adder_full_adder.sv
// Single-bit full adder used by both the carry-save and ripple stages.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/carry_save_adder.sv
// Two-stage pipelined A + B + C: registered carry-save layer, then a registered ripple resolve.
module carry_save_adder
    import carry_save_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [0:WIDTH-1] A,
    input  logic [0:WIDTH-1] B,
    input  logic [0:WIDTH-1] C,
    output logic [0:WIDTH] S,
    output logic           Cout
);

    localparam int unsigned RW = result_width(WIDTH);

    logic [0:WIDTH-1] sv;
    logic [0:WIDTH-1] cv;
    logic [0:WIDTH-1] sv_q;
    logic [0:WIDTH-1] cv_q;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_csa
            full_adder u_fa (
                .a    (A[i]),
                .b    (B[i]),
                .cin  (C[i]),
                .s    (sv[i]),
                .cout (cv[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv_q <= '0;
            cv_q <= '0;
        end else begin
            sv_q <= sv;
            cv_q <= cv;
        end
    end

    // Index 0 is the MSB, so the ripple runs from index WIDTH down to 0.
    logic [0:WIDTH]   op_x;
    logic [0:WIDTH]   op_y;
    logic [0:WIDTH]   sum;
    logic [0:WIDTH+1] carry;
    logic [0:RW-1]    result;

    assign op_x         = {1'b0, sv_q};
    assign op_y         = {cv_q, 1'b0};
    assign carry[WIDTH+1] = 1'b0;

    genvar j;
    generate
        for (j = 0; j <= WIDTH; j++) begin : g_rca
            full_adder u_fa (
                .a    (op_x[j]),
                .b    (op_y[j]),
                .cin  (carry[j+1]),
                .s    (sum[j]),
                .cout (carry[j])
            );
        end
    endgenerate

    assign result = {carry[0], sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            Cout <= 1'b0;
        end else begin
            S    <= result[1:RW-1];
            Cout <= result[0];
        end
    end

endmodule

// File: tb/tb_carry_save_adder.sv
// Self-checking bench for carry_save_adder against an arithmetic A+B+C model with 2-edge latency.
module tb_carry_save_adder;

    logic       clk;
    logic       rst_n;
    logic [0:3] A;
    logic [0:3] B;
    logic [0:3] C;
    logic [0:4] S;
    logic       Cout;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned q[$];

    carry_save_adder #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .C     (C),
        .S     (S),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned observed();
        return {26'b0, Cout, S};
    endfunction

    task automatic check(input string tag, input int unsigned expected);
        int unsigned obs;
        obs = observed();
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("FAIL %s: got Cout/S=%0d, expected %0d (A=%0d B=%0d C=%0d)",
                   tag, obs, expected, A, B, C);
        end
    endtask

    // Operands present at an edge emerge after the following edge; reset flushes anything in flight.
    task automatic tick(input string tag);
        int unsigned v;
        v = rst_n ? (int'(A) + int'(B) + int'(C)) : 0;
        q.push_back(v);
        @(posedge clk);
        #1;
        check(tag, q.pop_front());
    endtask

    task automatic apply(input int unsigned a, input int unsigned b, input int unsigned c);
        A = a[3:0];
        B = b[3:0];
        C = c[3:0];
    endtask

    initial begin
        rst_n = 1'b0;
        apply(15, 15, 15);
        q = '{0};
        #2;
        check("reset_async", 0);
        for (int i = 0; i < 3; i++) tick("reset_hold");

        rst_n = 1'b1;
        q = '{0};
        tick("post_reset_first");
        tick("post_reset_45");

        apply(0, 1, 1);   tick("basic_a");
        apply(12, 5, 12); tick("basic_b");
        apply(12, 10, 14); tick("carry_a");
        apply(15, 15, 7); tick("carry_b");
        tick("carry_b_hold");

        for (int i = 0; i < 15; i++) begin
            apply((i * 15) / 14, (i * 15) / 14, i / 2);
            tick("stream");
        end

        for (int i = 0; i < 6; i++) begin
            apply($urandom_range(15), $urandom_range(15), $urandom_range(15));
            tick("pre_midreset");
        end
        rst_n = 1'b0;
        #1;
        check("midreset_async", 0);
        #1;
        rst_n = 1'b1;
        q = '{0};
        for (int i = 0; i < 6; i++) begin
            apply($urandom_range(15), $urandom_range(15), $urandom_range(15));
            tick("post_midreset");
        end

        for (int i = 0; i < 4096; i++) begin
            apply((i >> 8) & 15, (i >> 4) & 15, i & 15);
            tick("exhaustive");
        end

        for (int i = 0; i < 300; i++) begin
            apply($urandom_range(15), $urandom_range(15), $urandom_range(15));
            tick("random");
        end
        tick("drain_a");
        tick("drain_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
